pwm_axil_slave: RTL and testbench
=================================

PWM_AXIL_SLAVE -- requirements
Module: pwm_axil_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width covering four 32-bit registers.
REQ-003 SHALL have one clock, s00_axi_aclk; reset s00_axi_aresetn is synchronous and active-low.
REQ-004 s00_axi_aclk  in  1  sole clock; all state changes on rising edge.
REQ-005 s00_axi_aresetn  in  1  synchronous active-low reset.
REQ-006 s00_axi_awaddr/awprot/awvalid  in  4/3/1; s00_axi_awready  out  1.  Write address channel; awprot ignored.
REQ-007 s00_axi_wdata/wstrb/wvalid  in  32/4/1; s00_axi_wready  out  1.  Write data channel.
REQ-008 s00_axi_bresp  out  2; s00_axi_bvalid  out  1; s00_axi_bready  in  1.  Write response channel.
REQ-009 s00_axi_araddr/arprot/arvalid  in  4/3/1; s00_axi_arready  out  1.  Read address channel; arprot ignored.
REQ-010 s00_axi_rdata  out  32; s00_axi_rresp  out  2; s00_axi_rvalid  out  1; s00_axi_rready  in  1.  Read data channel.
REQ-011 pwm_out  out  1  registered PWM output.
REQ-012 period_tick  out  1  one-cycle pulse at each PWM period start.

Function
REQ-013 Register map (addr[3:2]): 0 CTRL (bit0 enable, bit1 invert), 1 PERIOD, 2 DUTY, 3 PRESCALE; all 32 bits read/write storage; addr[1:0] ignored.
REQ-014 Readback of any register SHALL return exactly the last value written (all 32 bits), independent of shadow state.
REQ-015 Write accept: awready and wready SHALL pulse high together for one cycle when awvalid and wvalid are both high and bvalid is low; either channel may be presented first and SHALL wait for the other.
REQ-016 Register update SHALL occur on the accept cycle, byte lane n written only when wstrb[n]=1.
REQ-017 bvalid SHALL assert the cycle after accept with bresp=OKAY (2'b00), hold until bready, then deassert; no new write accepted while bvalid high.
REQ-018 Read accept: arready SHALL pulse one cycle when arvalid high and rvalid low; rvalid with rdata and rresp=OKAY the following cycle, held stable until rready.
REQ-019 Simultaneous read and write accept SHALL be permitted; read of the register written in the same cycle returns the old value.
REQ-020 Prescaler counter counts 0..PRESCALE, producing tick when equal to PRESCALE, then wraps to 0; PRESCALE=0 gives tick every cycle.
REQ-021 Period counter cnt advances on tick, counts 0..PERIOD_act-1, wraps to 0; period_tick pulses on the cycle cnt wraps to 0 (and on the first tick after enable).
REQ-022 PERIOD_act/DUTY_act shadow registers SHALL load from PERIOD/DUTY only when cnt wraps or while enable=0 (glitch-free updates).
REQ-023 pwm_out SHALL register ((cnt < DUTY_act) XOR invert): 1-cycle latency from counter state.
REQ-024 Boundaries: PERIOD_act=0 -> cnt held 0, raw output 0; DUTY_act>=PERIOD_act -> raw output constantly 1; DUTY_act=0 -> raw 0.
REQ-025 enable=0 SHALL clear both counters and drive pwm_out=invert the next cycle; enable 0->1 restarts from cnt=0.
REQ-026 Counter arithmetic SHALL be 32-bit unsigned without overflow (PERIOD up to 2^32-1).

Reset
REQ-027 On reset: all registers, shadows and counters 0; awready, wready, arready, bvalid, rvalid, period_tick, pwm_out 0; rdata 0; bresp/rresp 0.
REQ-028 Reset mid-transaction SHALL abandon any pending response without emitting it.

Structure
REQ-029 Shared package pwm_axil_pkg SHALL hold register offset constants, CTRL bit indices and the OKAY response constant.
REQ-030 PWM generation (prescaler, counter, shadows, compare) SHALL be one sub-module pwm_core; AXI-Lite register file stays in top.

Verification
REQ-031 Write 1,2,3,4 to 0x0,0x4,0x8,0xC then read back -> 0x1,0x2,0x3,0x4, all bresp/rresp OKAY.
REQ-032 wvalid 3 cycles before awvalid, bready held low 5 cycles -> single accept, bvalid held 5 cycles, no second accept.
REQ-033 PRESCALE=0, PERIOD=10, DUTY=3, CTRL=1 -> pwm_out high 3 of every 10 cycles, period_tick every 10 cycles.
REQ-034 Running at DUTY=3, write DUTY=7 mid-period -> change visible only after next period_tick.
REQ-035 DUTY=12, PERIOD=10 -> pwm_out constantly 1; CTRL=3 -> constantly 0; PERIOD=0 with invert=0 -> constantly 0.
REQ-036 wstrb=4'b0010 write 0xAABBCCDD to 0x8 holding 0x3 -> readback 0x0000CC03; reset asserted during pending bvalid -> bvalid 0 next cycle.

Source files
------------

// File: rtl/pwm_axil_pkg.sv
// pwm_axil_pkg: register map, CTRL bit positions and response codes
package pwm_axil_pkg;
  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_PERIOD   = 2'd1;
  localparam logic [1:0] REG_DUTY     = 2'd2;
  localparam logic [1:0] REG_PRESCALE = 2'd3;
  localparam int CTRL_EN  = 0;
  localparam int CTRL_INV = 1;
  localparam logic [1:0] RESP_OKAY = 2'b00;
endpackage

// File: rtl/pwm_axil_slave_if.sv
// pwm_axil_slave_if: AXI4-Lite bus bundle with master/slave views
interface pwm_axil_slave_if #(
  parameter int AW = 4,
  parameter int DW = 32
);
  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;
  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/pwm_core.sv
// pwm_core: prescaler, period counter, shadowed compare and registered PWM output
module pwm_core #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         inv_i,
  input  logic [W-1:0] period_i,
  input  logic [W-1:0] duty_i,
  input  logic [W-1:0] prescale_i,
  output logic         pwm_o,
  output logic         period_tick_o
);
  logic [W-1:0] pre_q, pre_d, cnt_q, cnt_d, per_q, per_d, duty_q, duty_d;
  logic first_q, first_d, pwm_q, pwm_d, pt_q, pt_d;
  logic tick, wrap, load;
  // Next state: >= on the prescaler recovers if PRESCALE is lowered below the running count
  always_comb begin
    tick    = pre_q >= prescale_i;
    wrap    = (per_q == '0) || (cnt_q >= per_q - W'(1));
    load    = ~en_i | (tick & wrap);
    pre_d   = (~en_i | tick) ? '0 : pre_q + W'(1);
    cnt_d   = (~en_i | (tick & wrap)) ? '0 : cnt_q + W'(tick);
    first_d = ~en_i | (first_q & ~tick);
    per_d   = load ? period_i : per_q;
    duty_d  = load ? duty_i : duty_q;
    pwm_d   = en_i ? (((per_q != '0) && (cnt_q < duty_q)) ^ inv_i) : inv_i;
    pt_d    = en_i & tick & (first_q | wrap);
  end
  // State registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pre_q   <= '0;
      cnt_q   <= '0;
      per_q   <= '0;
      duty_q  <= '0;
      first_q <= 1'b0;
      pwm_q   <= 1'b0;
      pt_q    <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      duty_q  <= duty_d;
      first_q <= first_d;
      pwm_q   <= pwm_d;
      pt_q    <= pt_d;
    end
  end
  assign pwm_o         = pwm_q;
  assign period_tick_o = pt_q;
endmodule

// File: rtl/pwm_axil_slave.sv
// pwm_axil_slave: AXI4-Lite register file driving a shadowed PWM generator
module pwm_axil_slave
  import pwm_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic             s00_axi_aclk,
  input  logic             s00_axi_aresetn,
  pwm_axil_slave_if.slave  s00_axi,
  output logic             pwm_out,
  output logic             period_tick
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int NB = DW / 8;
  localparam int AH = C_S_AXI_ADDR_WIDTH - 1;
  logic [DW-1:0] regs_q [4];
  logic [DW-1:0] regs_d [4];
  logic [DW-1:0] rdata_q, rdata_d;
  logic aw_rdy_q, aw_rdy_d, bvalid_q, bvalid_d, ar_rdy_q, ar_rdy_d, rvalid_q, rvalid_d;
  logic wr_acc, rd_acc;
  logic [1:0] wr_idx, rd_idx;
  logic unused_ok;
  assign wr_idx    = s00_axi.awaddr[AH -: 2];
  assign rd_idx    = s00_axi.araddr[AH -: 2];
  assign unused_ok = ^{s00_axi.awprot, s00_axi.arprot, s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};
  // Handshakes: ready pulses once both write channels are present and no response is outstanding
  always_comb begin
    wr_acc   = aw_rdy_q & s00_axi.awvalid & s00_axi.wvalid;
    rd_acc   = ar_rdy_q & s00_axi.arvalid;
    aw_rdy_d = s00_axi.awvalid & s00_axi.wvalid & ~bvalid_q & ~aw_rdy_q;
    bvalid_d = wr_acc | (bvalid_q & ~s00_axi.bready);
    ar_rdy_d = s00_axi.arvalid & ~rvalid_q & ~ar_rdy_q;
    rvalid_d = rd_acc | (rvalid_q & ~s00_axi.rready);
    rdata_d  = rd_acc ? regs_q[rd_idx] : rdata_q;
    regs_d   = regs_q;
    for (int b = 0; b < NB; b++)
      if (wr_acc && s00_axi.wstrb[b]) regs_d[wr_idx][8*b +: 8] = s00_axi.wdata[8*b +: 8];
  end
  // Bus state and register storage; reset drops any pending response
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      regs_q   <= '{default: '0};
      rdata_q  <= '0;
      aw_rdy_q <= 1'b0;
      bvalid_q <= 1'b0;
      ar_rdy_q <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      rdata_q  <= rdata_d;
      aw_rdy_q <= aw_rdy_d;
      bvalid_q <= bvalid_d;
      ar_rdy_q <= ar_rdy_d;
      rvalid_q <= rvalid_d;
    end
  end
  assign s00_axi.awready = aw_rdy_q;
  assign s00_axi.wready  = aw_rdy_q;
  assign s00_axi.bvalid  = bvalid_q;
  assign s00_axi.bresp   = RESP_OKAY;
  assign s00_axi.arready = ar_rdy_q;
  assign s00_axi.rvalid  = rvalid_q;
  assign s00_axi.rdata   = rdata_q;
  assign s00_axi.rresp   = RESP_OKAY;
  pwm_core #(.W(DW)) u_core (
    .clk_i        (s00_axi_aclk),
    .rst_ni       (s00_axi_aresetn),
    .en_i         (regs_q[REG_CTRL][CTRL_EN]),
    .inv_i        (regs_q[REG_CTRL][CTRL_INV]),
    .period_i     (regs_q[REG_PERIOD]),
    .duty_i       (regs_q[REG_DUTY]),
    .prescale_i   (regs_q[REG_PRESCALE]),
    .pwm_o        (pwm_out),
    .period_tick_o(period_tick)
  );
endmodule

// File: tb/tb_pwm_axil_slave.sv
// tb_pwm_axil_slave: directed and random AXI-Lite traffic against a cycle model of the PWM
module tb_pwm_axil_slave;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic pwm_out, period_tick;
  int checks = 0, errors = 0;
  pwm_axil_slave_if #(.AW(4), .DW(32)) bus ();
  pwm_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .s00_axi_aclk   (clk),
    .s00_axi_aresetn(rstn),
    .s00_axi        (bus),
    .pwm_out        (pwm_out),
    .period_tick    (period_tick)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model: register copy plus PWM behaviour in plain 64-bit arithmetic
  logic [31:0] r [4];
  longint m_pre, m_cnt, m_pa, m_da;
  bit m_first, m_en, m_inv, e_pwm, e_pt, mon;
  int acc_cnt = 0;

  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++) r[i] = '0;
      m_pre = 0; m_cnt = 0; m_pa = 0; m_da = 0; m_first = 0; e_pwm = 0; e_pt = 0;
    end else begin
      m_en = r[0][0];
      m_inv = r[0][1];
      e_pt = 0;
      if (!m_en) begin
        m_pre = 0; m_cnt = 0; m_first = 1; m_pa = r[1]; m_da = r[2]; e_pwm = m_inv;
      end else begin
        e_pwm = ((m_pa != 0 && m_cnt < m_da) ? 1'b1 : 1'b0) ^ m_inv;
        if (m_pre >= r[3]) begin
          m_pre = 0;
          if (m_pa == 0 || m_cnt + 1 >= m_pa) begin
            e_pt = 1; m_cnt = 0; m_pa = r[1]; m_da = r[2];
          end else begin
            e_pt = m_first; m_cnt = m_cnt + 1;
          end
          m_first = 0;
        end else m_pre = m_pre + 1;
      end
      if (bus.awvalid && bus.awready && bus.wvalid && bus.wready) begin
        for (int b = 0; b < 4; b++)
          if (bus.wstrb[b]) r[bus.awaddr[3:2]][8*b +: 8] = bus.wdata[8*b +: 8];
        acc_cnt++;
      end
    end
  end

  always @(negedge clk) if (mon) begin
    chk("pwm_out", pwm_out, e_pwm);
    chk("period_tick", period_tick, e_pt);
  end

  task automatic axi_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    bit ok = 0;
    @(negedge clk);
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s; bus.awvalid = 1; bus.wvalid = 1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = bus.awready && bus.wready;
    end
    chk("wr_accept", ok, 1);
    @(negedge clk);
    bus.awvalid = 0; bus.wvalid = 0;
    chk("bvalid", bus.bvalid, 1);
    chk("bresp", bus.bresp, 0);
    bus.bready = 1;
    @(negedge clk);
    bus.bready = 0;
    chk("bvalid_clear", bus.bvalid, 0);
  endtask

  task automatic axi_rd(input logic [3:0] a, output logic [31:0] d);
    bit ok = 0;
    @(negedge clk);
    bus.araddr = a; bus.arvalid = 1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = bus.arready;
    end
    chk("rd_accept", ok, 1);
    @(negedge clk);
    bus.arvalid = 0;
    chk("rvalid", bus.rvalid, 1);
    chk("rresp", bus.rresp, 0);
    d = bus.rdata;
    @(negedge clk);
    chk("rdata_stable", bus.rdata, d);
    chk("rvalid_hold", bus.rvalid, 1);
    bus.rready = 1;
    @(negedge clk);
    bus.rready = 0;
    chk("rvalid_clear", bus.rvalid, 0);
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    axi_rd(a, d);
    chk(tag, d, exp);
  endtask

  task automatic wait_pt();
    bit seen = 0;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge clk);
      seen = period_tick;
    end
    chk("period_tick_wait", seen, 1);
  endtask

  task automatic count_win(input int n, output int hi, output int pt);
    hi = 0; pt = 0;
    repeat (n) begin
      @(negedge clk);
      hi += int'(pwm_out);
      pt += int'(period_tick);
    end
  endtask

  initial begin
    int hi, pt, a0;
    bit ok, seen;
    logic [31:0] d;
    bus.awaddr = 0; bus.awprot = 0; bus.awvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wvalid = 0;
    bus.bready = 0; bus.araddr = 0; bus.arprot = 0; bus.arvalid = 0; bus.rready = 0;
    repeat (3) @(negedge clk);
    chk("rst_awready", bus.awready, 0);
    chk("rst_arready", bus.arready, 0);
    chk("rst_bvalid", bus.bvalid, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_resp", {bus.bresp, bus.rresp}, 0);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_ptick", period_tick, 0);
    mon = 1;
    rstn = 1;
    for (int i = 0; i < 4; i++) axi_wr(4'(4 * i), 32'(i + 1));
    for (int i = 0; i < 4; i++) rd_chk("readback", 4'(4 * i), 32'(i + 1));
    fork
      axi_wr(4'h4, 32'h11);
      axi_rd(4'h4, d);
    join
    chk("same_cycle_old", d, 32'h2);
    rd_chk("same_cycle_new", 4'h5, 32'h11);
    axi_wr(4'h8, 32'h3);
    axi_wr(4'h8, 32'hAABBCCDD, 4'b0010);
    rd_chk("wstrb_lane1", 4'h8, 32'h0000CC03);
    // reset while a write response is pending
    @(negedge clk);
    bus.awaddr = 4'h0; bus.wdata = 32'h5; bus.wstrb = 4'hF; bus.awvalid = 1; bus.wvalid = 1;
    ok = 0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = bus.awready;
    end
    chk("pre_rst_accept", ok, 1);
    @(negedge clk);
    bus.awvalid = 0; bus.wvalid = 0;
    chk("pre_rst_bvalid", bus.bvalid, 1);
    rstn = 0;
    @(negedge clk);
    chk("rst_drops_bvalid", bus.bvalid, 0);
    rstn = 1;
    rd_chk("rst_clears_ctrl", 4'h0, 0);
    rd_chk("rst_clears_duty", 4'h8, 0);
    // data channel first, then a held-off response with a second write queued
    a0 = acc_cnt;
    @(negedge clk);
    bus.wdata = 32'h7; bus.wstrb = 4'hF; bus.wvalid = 1;
    repeat (3) begin
      @(negedge clk);
      chk("early_ready", {bus.awready, bus.wready}, 0);
    end
    bus.awaddr = 4'hC; bus.awvalid = 1;
    ok = 0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = bus.awready && bus.wready;
    end
    chk("late_accept", ok, 1);
    @(negedge clk);
    bus.awaddr = 4'h8; bus.wdata = 32'h55;
    repeat (5) begin
      chk("bvalid_hold", bus.bvalid, 1);
      chk("no_accept_in_hold", bus.awready, 0);
      @(negedge clk);
    end
    chk("single_accept", acc_cnt - a0, 1);
    bus.bready = 1;
    ok = 0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = bus.awready && bus.wready;
    end
    chk("second_accept", ok, 1);
    @(negedge clk);
    bus.awvalid = 0; bus.wvalid = 0;
    @(negedge clk);
    bus.bready = 0;
    chk("bvalid_done", bus.bvalid, 0);
    chk("two_accepts", acc_cnt - a0, 2);
    rd_chk("first_write", 4'hC, 32'h7);
    rd_chk("second_write", 4'h8, 32'h55);
    // steady waveform: 3 high of every 10
    axi_wr(4'hC, 0);
    axi_wr(4'h4, 10);
    axi_wr(4'h8, 3);
    axi_wr(4'h0, 1);
    wait_pt();
    wait_pt();
    count_win(10, hi, pt);
    chk("duty3_high", hi, 3);
    chk("duty3_ticks", pt, 1);
    chk("tick_at_period", period_tick, 1);
    // duty change mid-period only takes effect after the next period start
    axi_wr(4'h4, 20);
    wait_pt();
    wait_pt();
    repeat (5) @(negedge clk);
    axi_wr(4'h8, 7);
    hi = 0; seen = 0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      seen = period_tick;
      if (!seen) hi += int'(pwm_out);
    end
    chk("tail_wait", seen, 1);
    chk("tail_old_duty", hi, 0);
    count_win(20, hi, pt);
    chk("duty7_high", hi, 7);
    chk("duty7_ticks", pt, 1);
    // boundary cases
    axi_wr(4'h4, 10);
    axi_wr(4'h8, 12);
    wait_pt();
    wait_pt();
    count_win(20, hi, pt);
    chk("duty_over_period", hi, 20);
    axi_wr(4'h0, 3);
    count_win(20, hi, pt);
    chk("inverted_full", hi, 0);
    axi_wr(4'h0, 1);
    axi_wr(4'h4, 0);
    wait_pt();
    wait_pt();
    count_win(20, hi, pt);
    chk("period_zero", hi, 0);
    axi_wr(4'h0, 2);
    count_win(5, hi, pt);
    chk("disabled_inv", hi, 5);
    chk("disabled_ticks", pt, 0);
    // random register traffic, checked cycle by cycle by the model
    for (int k = 0; k < 40; k++) begin
      int op, a;
      logic [31:0] v;
      logic [3:0] s;
      op = $urandom_range(0, 2);
      a = $urandom_range(0, 3);
      if (op == 0) begin
        v = (a == 0) ? 32'($urandom_range(0, 3)) : (a == 1) ? 32'($urandom_range(0, 15)) :
            (a == 2) ? 32'($urandom_range(0, 17)) : 32'($urandom_range(0, 2));
        s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
        axi_wr({2'(a), 2'($urandom_range(0, 3))}, v, s);
      end else if (op == 1) begin
        axi_rd({2'(a), 2'($urandom_range(0, 3))}, d);
        chk("rand_readback", d, r[a]);
      end else repeat ($urandom_range(1, 40)) @(negedge clk);
    end
    mon = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
